jtcop_objdma: RTL and testbench

Object RAM DMA controller for the Sly Spy / DEC0 object path. On each copy request (the *DM strobe, one per frame at VBLANK start) it takes ownership of the CPU-side object RAM and copies it word by word into the object engine's line buffer source (shadow RAM). With the configuration macro it sequences the 68000 bus request/grant handshake; without it, it shares the RAM port by stealing cycles the CPU leaves free. It sits between the address decoder's `obj_copy`/`obj_cs` outputs, the object RAM and the object shadow buffer.

---
 rtl/jtcop_objdma.sv | 169 ++++++++++++++++
 tb/tb_jtcop_objdma.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_objdma.sv
// Object RAM -> object shadow buffer DMA, one full copy per obj_copy request.
// Define JTCOP_OBJDMA_HALT_EN to halt the 68000 via BRn/BGn/BGACKn; otherwise free CPU cycles are stolen.
module jtcop_objdma #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          obj_copy,
  input  logic          LVBL,
  input  logic          cpu_cs,
  output logic          BRn,
  input  logic          BGn,
  output logic          BGACKn,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done,
  output logic          late
);

`ifdef JTCOP_OBJDMA_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT_BG, COPY, FLUSH, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic          rd_vld_q, rd_vld_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          late_q, late_d;
  logic          lvbl_q, lvbl_d;
  logic          brn_q, brn_d;
  logic          bgackn_q, bgackn_d;
  logic          buf_we_q, buf_we_d;
  logic          start, stall;

  // Without the bus handshake the CPU keeps priority on the RAM port.
  assign stall = ~HALT_EN & cpu_cs;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    buf_addr_d = buf_addr_q;
    rd_vld_d   = 1'b0;
    pending_d  = pending_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    late_d     = late_q;
    lvbl_d     = LVBL;
    brn_d      = brn_q;
    bgackn_d   = bgackn_q;
    buf_we_d   = 1'b0;
    start      = 1'b0;

    if (LVBL && !lvbl_q && busy_q) late_d = 1'b1;
    if (obj_copy && busy_q && state_q != RELEASE) pending_d = 1'b1;

    case (state_q)
      IDLE:    start = obj_copy;
      REQ:     state_d = WAIT_BG;
      WAIT_BG: begin
        if (!BGn) begin
          brn_d      = 1'b1;
          bgackn_d   = 1'b0;
          state_d    = COPY;
          ram_addr_d = '0;
          cnt_d      = (AW+1)'(1);
          rd_vld_d   = 1'b1;
        end
      end
      COPY: begin
        // Data for the address issued last clk arrives now; write it behind the read.
        buf_we_d   = rd_vld_q;
        buf_addr_d = ram_addr_q;
        if (cnt_q[AW]) begin
          state_d = FLUSH;
          done_d  = 1'b1;
        end else if (!stall) begin
          ram_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + (AW+1)'(1);
          rd_vld_d   = 1'b1;
        end
      end
      FLUSH: begin
        state_d  = RELEASE;
        bgackn_d = 1'b1;
      end
      RELEASE: begin
        start     = pending_q | obj_copy;
        pending_d = 1'b0;
        if (!start) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      busy_d    = 1'b1;
      late_d    = 1'b0;
      pending_d = 1'b0;
      if (HALT_EN) begin
        state_d = REQ;
        brn_d   = 1'b0;
      end else begin
        state_d    = COPY;
        ram_addr_d = '0;
        cnt_d      = (AW+1)'(1);
        rd_vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      buf_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      late_q     <= 1'b0;
      lvbl_q     <= 1'b1;
      brn_q      <= 1'b1;
      bgackn_q   <= 1'b1;
      buf_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      buf_addr_q <= buf_addr_d;
      rd_vld_q   <= rd_vld_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      late_q     <= late_d;
      lvbl_q     <= lvbl_d;
      brn_q      <= brn_d;
      bgackn_q   <= bgackn_d;
      buf_we_q   <= buf_we_d;
    end
  end

  assign BRn      = brn_q | ~HALT_EN;
  assign BGACKn   = bgackn_q | ~HALT_EN;
  assign ram_addr = ram_addr_q;
  assign buf_addr = buf_addr_q;
  assign buf_we   = buf_we_q;
  // RAM data is valid exactly in the write clk; zero it otherwise so the bus idles clean.
  assign buf_din  = buf_we_q ? ram_dout : 16'h0000;
  assign busy     = busy_q;
  assign done     = done_q;
  assign late     = late_q;

endmodule

// File: tb/tb_jtcop_objdma.sv
// Scoreboard bench for jtcop_objdma: expected shadow writes queued at each request, checked per write.
module tb_jtcop_objdma;
  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          obj_copy = 1'b0;
  logic          LVBL = 1'b0;
  logic          cpu_cs = 1'b0;
  logic          BGn = 1'b1;
  logic          BRn, BGACKn, buf_we, busy, done, late;
  logic [AW-1:0] ram_addr, buf_addr;
  logic [15:0]   ram_dout, buf_din;

  logic [15:0]    mem [N];
  logic [AW+15:0] exp_q [$];
  int n_cmp = 0, n_fail = 0;
  int done_cnt = 0, bgack_low = 0, brn_low_seen = 0;
  int grant_dly = 0, brn_run = 0;
  bit hold_bg = 1'b0;

  always #5 clk = ~clk;

  jtcop_objdma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .obj_copy(obj_copy), .LVBL(LVBL), .cpu_cs(cpu_cs),
    .BRn(BRn), .BGn(BGn), .BGACKn(BGACKn), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .busy(busy),
    .done(done), .late(late)
  );

  // Synchronous-read object RAM
  always @(posedge clk) ram_dout <= mem[ram_addr];

  // 68000 bus arbiter: grants grant_dly clks after BRn falls unless held off
  always @(posedge clk) begin
    #1;
    if (BRn === 1'b0) brn_run++; else brn_run = 0;
    BGn = !(BRn === 1'b0 && brn_run > grant_dly && !hold_bg);
  end

  // Shadow buffer side: every write must be the next queued (addr,data)
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (done === 1'b1) done_cnt++;
    if (BGACKn === 1'b0) bgack_low++;
    if (BRn === 1'b0) brn_low_seen++;
    if (buf_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", buf_addr, buf_din);
      end else begin
        e = exp_q.pop_front();
        if ({buf_addr, buf_din} !== e) begin
          n_fail++;
          $display("FAIL buf_write: addr=%0d data=%h want addr=%0d data=%h",
                   buf_addr, buf_din, e[AW+15:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load_mem(input logic [15:0] seed);
    for (int i = 0; i < N; i++) mem[i] = 16'(i) ^ 16'hA5A5 ^ seed;
  endtask

  task automatic push_copy;
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), mem[i]});
  endtask

  task automatic pulse_copy;
    obj_copy = 1'b1; tick; obj_copy = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin tick; cyc++; end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; obj_copy = 1'b0; LVBL = 1'b0; cpu_cs = 1'b0;
    load_mem(16'h0000);
    repeat (3) tick;
    n_cmp++; if ({BRn, BGACKn, buf_we, busy, done, late} !== 6'b110000) begin n_fail++; $display("FAIL reset_ctrl: {BRn,BGACKn,we,busy,done,late}=%b want 110000", {BRn, BGACKn, buf_we, busy, done, late}); end
    n_cmp++; if ({ram_addr, buf_addr, buf_din} !== '0) begin n_fail++; $display("FAIL reset_data: ram_addr=%0d buf_addr=%0d buf_din=%h want 0", ram_addr, buf_addr, buf_din); end
    rst = 1'b0; repeat (2) tick;
    n_cmp++; if ({BRn, BGACKn, buf_we, busy, done, late} !== 6'b110000) begin n_fail++; $display("FAIL idle_ctrl: %b want 110000", {BRn, BGACKn, buf_we, busy, done, late}); end
  endtask

  task automatic test_copy;
    int cyc, d0, b0;
    load_mem(16'h0000); grant_dly = 3; d0 = done_cnt; b0 = bgack_low;
    push_copy(); pulse_copy();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL copy_busy: busy=%b want 1", busy); end
`ifdef JTCOP_OBJDMA_HALT_EN
    n_cmp++; if (BRn !== 1'b0) begin n_fail++; $display("FAIL copy_brn: BRn=%b want 0", BRn); end
`else
    n_cmp++; if (ram_addr !== '0) begin n_fail++; $display("FAIL copy_first_addr: ram_addr=%0d want 0", ram_addr); end
`endif
    wait_done(3000, cyc);
`ifdef JTCOP_OBJDMA_HALT_EN
    n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL copy_done: timeout want done"); end
`else
    n_cmp++; if (cyc != N) begin n_fail++; $display("FAIL copy_latency: done %0d clks after accept want %0d", cyc, N); end
`endif
    tick;
    n_cmp++; if (BGACKn !== 1'b1) begin n_fail++; $display("FAIL copy_bgack_rel: BGACKn=%b want 1", BGACKn); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_idle: busy=%b want 0", busy); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL copy_done_cnt: %0d want 1", done_cnt - d0); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL copy_words: %0d words missing want 0", exp_q.size()); end
`ifdef JTCOP_OBJDMA_HALT_EN
    n_cmp++; if (bgack_low - b0 != N + 1) begin n_fail++; $display("FAIL copy_bgack_len: %0d clks want %0d", bgack_low - b0, N + 1); end
`endif
  endtask

  task automatic test_pending;
    int c1, c2, d0;
    load_mem(16'h1234); grant_dly = 1; d0 = done_cnt;
    push_copy(); pulse_copy();
    repeat (100) tick;
    push_copy(); pulse_copy();
    repeat (100) tick;
    pulse_copy();
    wait_done(3000, c1); tick; wait_done(4000, c2);
    n_cmp++; if (c1 < 0 || c2 < 0) begin n_fail++; $display("FAIL pend_done: c1=%0d c2=%0d want both >=0", c1, c2); end
    repeat (1500) tick;
    n_cmp++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL pend_count: %0d copies want 2", done_cnt - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_idle: busy=%b want 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pend_words: %0d missing want 0", exp_q.size()); end
  endtask

  task automatic test_done_coincident;
    int c1, c2, d0;
    load_mem(16'h0F0F); d0 = done_cnt;
    push_copy(); pulse_copy();
    wait_done(3000, c1);
    push_copy(); pulse_copy();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL coinc_busy: busy=%b want 1", busy); end
    wait_done(4000, c2);
    n_cmp++; if (c1 < 0 || c2 < 0) begin n_fail++; $display("FAIL coinc_done: c1=%0d c2=%0d want both >=0", c1, c2); end
    repeat (3) tick;
    n_cmp++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL coinc_count: %0d copies want 2", done_cnt - d0); end
    n_cmp++; if (exp_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL coinc_end: missing=%0d busy=%b want 0/0", exp_q.size(), busy); end
  endtask

  task automatic test_late;
    int c;
    load_mem(16'h7777); LVBL = 1'b0;
    push_copy(); pulse_copy();
    repeat (100) tick;
    LVBL = 1'b1; tick;
    n_cmp++; if (late !== 1'b1) begin n_fail++; $display("FAIL late_set: late=%b want 1", late); end
    wait_done(3000, c); repeat (3) tick;
    n_cmp++; if (late !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL late_sticky: late=%b busy=%b want 1/0", late, busy); end
    LVBL = 1'b0; tick;
    push_copy(); pulse_copy();
    n_cmp++; if (late !== 1'b0) begin n_fail++; $display("FAIL late_clear: late=%b want 0", late); end
    wait_done(3000, c); repeat (3) tick;
    LVBL = 1'b1; repeat (2) tick;
    n_cmp++; if (late !== 1'b0 || c < 0) begin n_fail++; $display("FAIL late_idle_rise: late=%b cyc=%0d want 0", late, c); end
    LVBL = 1'b0; tick;
  endtask

  task automatic test_rst_mid;
    int n, c;
    load_mem(16'h5A5A);
    push_copy(); pulse_copy();
    n = 0;
    while (!(buf_we === 1'b1 && buf_addr == AW'(300)) && n < 3000) begin tick; n++; end
    n_cmp++; if (n >= 3000) begin n_fail++; $display("FAIL rst_reach300: timeout want word 300"); end
    rst = 1'b1; #1;
    n_cmp++; if ({BRn, BGACKn, busy, buf_we, done} !== 5'b11000) begin n_fail++; $display("FAIL rst_mid_ctrl: {BRn,BGACKn,busy,we,done}=%b want 11000", {BRn, BGACKn, busy, buf_we, done}); end
    n_cmp++; if ({ram_addr, buf_addr, buf_din} !== '0) begin n_fail++; $display("FAIL rst_mid_data: ram_addr=%0d buf_addr=%0d din=%h want 0", ram_addr, buf_addr, buf_din); end
    exp_q.delete();
    repeat (2) tick;
    rst = 1'b0; tick;
    load_mem(16'hC3C3);
    push_copy(); pulse_copy();
    wait_done(3000, c); repeat (3) tick;
    n_cmp++; if (c < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rst_recopy: cyc=%0d missing=%0d want >=0/0", c, exp_q.size()); end
  endtask

`ifdef JTCOP_OBJDMA_HALT_EN
  task automatic test_immediate_grant;
    int c;
    load_mem(16'h3C3C); grant_dly = 0;
    push_copy(); pulse_copy();
    n_cmp++; if ({BRn, BGACKn} !== 2'b01) begin n_fail++; $display("FAIL ig_t1: {BRn,BGACKn}=%b want 01", {BRn, BGACKn}); end
    tick;
    n_cmp++; if ({BRn, BGACKn} !== 2'b01) begin n_fail++; $display("FAIL ig_t2: {BRn,BGACKn}=%b want 01", {BRn, BGACKn}); end
    tick;
    n_cmp++; if ({BRn, BGACKn, buf_we} !== 3'b100) begin n_fail++; $display("FAIL ig_t3: {BRn,BGACKn,we}=%b want 100", {BRn, BGACKn, buf_we}); end
    tick;
    n_cmp++; if (buf_we !== 1'b1 || buf_addr !== '0) begin n_fail++; $display("FAIL ig_t4: we=%b addr=%0d want 1/0", buf_we, buf_addr); end
    wait_done(3000, c); repeat (3) tick;
    n_cmp++; if (c < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL ig_end: cyc=%0d missing=%0d", c, exp_q.size()); end
  endtask

  task automatic test_grant_hold;
    int c, brn_hi, we_seen, busy_lo;
    load_mem(16'h9999); hold_bg = 1'b1; brn_hi = 0; we_seen = 0; busy_lo = 0;
    push_copy(); pulse_copy();
    repeat (50) begin
      tick;
      if (BRn !== 1'b0) brn_hi++;
      if (buf_we !== 1'b0) we_seen++;
      if (busy !== 1'b1) busy_lo++;
    end
    n_cmp++; if (brn_hi != 0) begin n_fail++; $display("FAIL hold_brn: %0d clks BRn high want 0", brn_hi); end
    n_cmp++; if (we_seen != 0) begin n_fail++; $display("FAIL hold_we: %0d writes want 0", we_seen); end
    n_cmp++; if (busy_lo != 0) begin n_fail++; $display("FAIL hold_busy: %0d clks idle want 0", busy_lo); end
    hold_bg = 1'b0;
    wait_done(3000, c); repeat (3) tick;
    n_cmp++; if (c < 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL hold_end: cyc=%0d missing=%0d", c, exp_q.size()); end
  endtask
`else
  task automatic test_steal;
    int n;
    load_mem(16'hBEEF);
    push_copy(); pulse_copy();
    n = 0; cpu_cs = 1'b1;
    while (done !== 1'b1 && n < 5000) begin tick; n++; cpu_cs = (n % 2 == 0); end
    cpu_cs = 1'b0;
    n_cmp++; if (n != 2047) begin n_fail++; $display("FAIL steal_len: done %0d clks after accept want 2047", n); end
    repeat (3) tick;
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL steal_words: %0d missing want 0", exp_q.size()); end
    n_cmp++; if (brn_low_seen != 0 || bgack_low != 0) begin n_fail++; $display("FAIL steal_bus: BRn low %0d, BGACKn low %0d clks want 0/0", brn_low_seen, bgack_low); end
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_pending();
    test_done_coincident();
    test_late();
    test_rst_mid();
`ifdef JTCOP_OBJDMA_HALT_EN
    test_immediate_grant();
    test_grant_hold();
`else
    test_steal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
